card_grid_ctrl: RTL and testbench
=================================

// Module: card_grid_ctrl
// PURPOSE
//  Parametrised game-logic core for the memory game: a ROWS x COLS card grid with
//  pairs matched by mouse click. Hit-tests the mouse position against the card
//  rectangles, flips cards, compares pairs, holds mismatches for a timed reveal, and
//  counts moves and detects a win. It sits between the mouse delay stage and the card
//  renderer, and is clocked on the 65 MHz pixel clock.
// PARAMETERS
//  COLS        4          cards per row (1..8)
//  ROWS        4          card rows (1..8); COLS*ROWS must be even
//  VAL_W       4          bits per card value (pair id)
//  GRID_X      112        x of top-left card, pixels
//  GRID_Y      84         y of top-left card, pixels
//  CARD_W      160        card width, pixels
//  CARD_H      120        card height, pixels
//  GAP         40         spacing between cards, both axes, pixels
//  SHOW_CYCLES 65000000   mismatch reveal time in clk cycles (1 s @ 65 MHz), >=1
// PORTS  (N = COLS*ROWS)
//  clk          in   1        65 MHz pixel clock
//  rst          in   1        asynchronous, active-low reset
//  start        in   1        game active level from the game state machine
//  mouse_xpos   in   12       cursor x, synchronous to clk
//  mouse_ypos   in   12       cursor y, synchronous to clk
//  mouse_left   in   1        left button level, synchronous to clk
//  card_values  in   N*VAL_W  packed pair ids; card i at [i*VAL_W +: VAL_W]; i = row*COLS+col
//  face_up      out  N        card i shown face up
//  matched      out  N        card i permanently matched
//  moves        out  16       completed pair attempts, saturating at 16'hFFFF
//  game_won     out  1        all N cards matched
//  busy         out  1        high in COMPARE/SHOW; clicks ignored
// BEHAVIOUR
//  - Reset (rst=0): state IDLE; face_up, matched, moves, game_won, busy all 0.
//  - Click = rising edge of mouse_left (registered previous level); one click per edge.
//  - Hit test per axis by comparison, no division: col c hit when
//    GRID_X+c*(CARD_W+GAP) <= x < GRID_X+c*(CARD_W+GAP)+CARD_W; same for rows.
//    A click in a gap or outside the grid is a miss and is ignored.
//  - Pipeline: edge+hit registered in cycle 1, state update in cycle 2; face_up
//    changes 2 clks after the mouse_left rise is sampled.
//  - FSM:
//    IDLE   : all outputs 0; start=1 -> WAIT1 (clears face_up/matched/moves).
//    WAIT1  : hit on card i with !face_up[i] && !matched[i] -> face_up[i]=1, first=i, WAIT2.
//    WAIT2  : hit on card j, same validity check (j==first is invalid) -> face_up[j]=1,
//             second=j, moves++ (saturating), COMPARE.
//    COMPARE: 1 clk. Values equal -> matched[first],matched[second]=1; all matched -> WON
//             else WAIT1. Values differ -> load timer SHOW_CYCLES-1, SHOW.
//    SHOW   : clicks ignored; timer==0 -> clear face_up[first],face_up[second], WAIT1.
//    WON    : game_won=1; hold all outputs until start=0.
//  - start=0 in any non-IDLE state -> IDLE next clk; outputs cleared (abort mid-game).
//  - Matched cards keep face_up=1. Clicks on face-up or matched cards are ignored.
//  - A click arriving in COMPARE/SHOW is dropped, not queued.
//  - Reset asserted mid-game returns to IDLE immediately (asynchronous reset).
// CONFIGURATION
//  CARD_GRID_HOVER_EN defined: extra outputs hover_idx [$clog2(N)-1:0] and hover_valid
//    (1), registered every clk from the same hit logic, with 1 clk latency. They are 0
//    in reset/IDLE and drive highlight rendering.
//  Not defined: those ports do not exist; no hover logic is built.
// TESTING
//  1 Reset, start=1, click centre of card 0 (192,144) -> face_up=16'h0001 2 clks later.
//  2 Values 0,0 at cards 0,1; click both -> COMPARE, matched=16'h0003, moves=1, WAIT1.
//  3 Values differ at cards 0,2, SHOW_CYCLES=10 -> face_up=0x0005 for 10 clks then 0x0000;
//    a click during SHOW leaves face_up unchanged.
//  4 Click at (272,144) in a gap, then click card 0 twice -> no change; moves stays 0.
//  5 Match all 8 pairs -> game_won=1, matched=16'hFFFF; start=0 -> all outputs 0 next clk.
//  6 rst=0 asynchronously while in SHOW -> outputs 0 without a clk edge; with HOVER_EN,
//    cursor at (192,144) -> hover_idx=0, hover_valid=1.

Source files
------------

// File: rtl/card_grid_ctrl.sv
// card_grid_ctrl: memory-game core for a ROWS x COLS card grid.
// Hit-tests the cursor against the card rectangles, flips cards on click,
// compares pairs, holds a mismatch face-up for SHOW_CYCLES, counts moves
// and flags a win.
// Optional feature: define CARD_GRID_HOVER_EN to add hover_idx/hover_valid.
module card_grid_ctrl #(
  parameter int unsigned COLS        = 4,
  parameter int unsigned ROWS        = 4,
  parameter int unsigned VAL_W       = 4,
  parameter int unsigned GRID_X      = 112,
  parameter int unsigned GRID_Y      = 84,
  parameter int unsigned CARD_W      = 160,
  parameter int unsigned CARD_H      = 120,
  parameter int unsigned GAP         = 40,
  parameter int unsigned SHOW_CYCLES = 65000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [11:0]                   mouse_xpos,
  input  logic [11:0]                   mouse_ypos,
  input  logic                          mouse_left,
  input  logic [COLS*ROWS*VAL_W-1:0]    card_values,
  output logic [COLS*ROWS-1:0]          face_up,
  output logic [COLS*ROWS-1:0]          matched,
  output logic [15:0]                   moves,
  output logic                          game_won,
  output logic                          busy
`ifdef CARD_GRID_HOVER_EN
  ,
  output logic [$clog2(COLS*ROWS)-1:0]  hover_idx,
  output logic                          hover_valid
`endif
);

  localparam int unsigned N     = COLS * ROWS;
  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned TMR_W = $clog2(SHOW_CYCLES + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT1   = 3'd1;
  localparam logic [2:0] S_WAIT2   = 3'd2;
  localparam logic [2:0] S_COMPARE = 3'd3;
  localparam logic [2:0] S_SHOW    = 3'd4;
  localparam logic [2:0] S_WON     = 3'd5;

  logic [2:0]       r_state;
  logic [N-1:0]     r_face_up;
  logic [N-1:0]     r_matched;
  logic [15:0]      r_moves;
  logic [IDX_W-1:0] r_first;
  logic [IDX_W-1:0] r_second;
  logic [TMR_W-1:0] r_timer;
  logic             r_prev_left;
  logic             r_click;
  logic [IDX_W-1:0] r_click_idx;

  logic [31:0]      w_x;
  logic [31:0]      w_y;
  logic [31:0]      w_col;
  logic [31:0]      w_row;
  logic             w_col_hit;
  logic             w_row_hit;
  logic             w_hit;
  logic [IDX_W-1:0] w_hit_idx;
  logic [VAL_W-1:0] w_val_a;
  logic [VAL_W-1:0] w_val_b;
  logic [N-1:0]     w_pair_mask;
  logic             w_click_ok;

  // Per-axis rectangle hit test by comparison against each card's span.
  always_comb begin
    w_x       = {20'd0, mouse_xpos};
    w_y       = {20'd0, mouse_ypos};
    w_col_hit = 1'b0;
    w_col     = '0;
    w_row_hit = 1'b0;
    w_row     = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if ((w_x >= GRID_X + c * (CARD_W + GAP)) &&
          (w_x <  GRID_X + c * (CARD_W + GAP) + CARD_W)) begin
        w_col_hit = 1'b1;
        w_col     = c;
      end
    end
    for (int unsigned r = 0; r < ROWS; r++) begin
      if ((w_y >= GRID_Y + r * (CARD_H + GAP)) &&
          (w_y <  GRID_Y + r * (CARD_H + GAP) + CARD_H)) begin
        w_row_hit = 1'b1;
        w_row     = r;
      end
    end
    w_hit     = w_col_hit & w_row_hit;
    w_hit_idx = IDX_W'(w_row * COLS + w_col);
  end

  // Select the two flipped cards' values and build their one-hot mask.
  always_comb begin
    w_val_a     = '0;
    w_val_b     = '0;
    w_pair_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (IDX_W'(i) == r_first) begin
        w_val_a        = card_values[i*VAL_W +: VAL_W];
        w_pair_mask[i] = 1'b1;
      end
      if (IDX_W'(i) == r_second) begin
        w_val_b        = card_values[i*VAL_W +: VAL_W];
        w_pair_mask[i] = 1'b1;
      end
    end
    w_click_ok = r_click & ~r_face_up[r_click_idx] & ~r_matched[r_click_idx];
  end

  // Click pipeline stage: button rising edge qualified by a card hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev_left <= 1'b0;
      r_click     <= 1'b0;
      r_click_idx <= '0;
    end else begin
      r_prev_left <= mouse_left;
      r_click     <= mouse_left & ~r_prev_left & w_hit;
      r_click_idx <= w_hit_idx;
    end
  end

  // Game FSM: flip, compare, timed reveal, win; dropping start aborts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_face_up <= '0;
      r_matched <= '0;
      r_moves   <= '0;
      r_first   <= '0;
      r_second  <= '0;
      r_timer   <= '0;
    end else if ((r_state != S_IDLE) && !start) begin
      r_state   <= S_IDLE;
      r_face_up <= '0;
      r_matched <= '0;
      r_moves   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_WAIT1;
            r_face_up <= '0;
            r_matched <= '0;
            r_moves   <= '0;
          end
        end
        S_WAIT1: begin
          if (w_click_ok) begin
            r_face_up[r_click_idx] <= 1'b1;
            r_first                <= r_click_idx;
            r_state                <= S_WAIT2;
          end
        end
        S_WAIT2: begin
          // the first card is already face up, so re-clicking it is rejected here
          if (w_click_ok) begin
            r_face_up[r_click_idx] <= 1'b1;
            r_second               <= r_click_idx;
            if (r_moves != 16'hFFFF) r_moves <= r_moves + 16'd1;
            r_state                <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (w_val_a == w_val_b) begin
            r_matched <= r_matched | w_pair_mask;
            r_state   <= ((r_matched | w_pair_mask) == '1) ? S_WON : S_WAIT1;
          end else begin
            r_timer <= TMR_W'(SHOW_CYCLES - 1);
            r_state <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (r_timer == '0) begin
            r_face_up <= r_face_up & ~w_pair_mask;
            r_state   <= S_WAIT1;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        S_WON: begin
          r_state <= S_WON;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CARD_GRID_HOVER_EN
  logic [IDX_W-1:0] r_hover_idx;
  logic             r_hover_valid;

  // Registered cursor-over-card indication for highlight rendering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hover_idx   <= '0;
      r_hover_valid <= 1'b0;
    end else begin
      r_hover_valid <= (r_state != S_IDLE) && start && w_hit;
      r_hover_idx   <= ((r_state != S_IDLE) && start && w_hit) ? w_hit_idx : '0;
    end
  end

  assign hover_idx   = r_hover_idx;
  assign hover_valid = r_hover_valid;
`endif

  assign face_up  = r_face_up;
  assign matched  = r_matched;
  assign moves    = r_moves;
  assign game_won = (r_state == S_WON);
  assign busy     = (r_state == S_COMPARE) || (r_state == S_SHOW);

endmodule

// File: tb/tb_card_grid_ctrl.sv
// Scoreboard bench for card_grid_ctrl: stimulus queues expected output
// snapshots (with the cycle they must appear on); a monitor pops one on
// every output change or explicit probe and compares.
module tb_card_grid_ctrl;

  localparam int unsigned SHOW = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] mx = '0;
  logic [11:0] my = '0;
  logic        ml = 1'b0;
  logic [63:0] cv;
  logic [15:0] face_up;
  logic [15:0] matched;
  logic [15:0] moves;
  logic        game_won;
  logic        busy;
`ifdef CARD_GRID_HOVER_EN
  logic [3:0]  hover_idx;
  logic        hover_valid;
`endif

  card_grid_ctrl #(
    .COLS(4), .ROWS(4), .VAL_W(4), .GRID_X(112), .GRID_Y(84),
    .CARD_W(160), .CARD_H(120), .GAP(40), .SHOW_CYCLES(SHOW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .mouse_xpos(mx), .mouse_ypos(my), .mouse_left(ml),
    .card_values(cv),
    .face_up(face_up), .matched(matched), .moves(moves),
    .game_won(game_won), .busy(busy)
`ifdef CARD_GRID_HOVER_EN
    , .hover_idx(hover_idx), .hover_valid(hover_valid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] fu;
    logic [15:0] mt;
    logic [15:0] mv;
    logic        won;
    logic        bsy;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        probe_tgl = 1'b0;
  logic [49:0] snap;

  assign snap = {face_up, matched, moves, game_won, busy};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input string n, input logic [15:0] fu, input logic [15:0] mt,
                      input logic [15:0] mv, input logic won, input logic bsy, input int c);
    exp_t e;
    e.name = n; e.fu = fu; e.mt = mt; e.mv = mv; e.won = won; e.bsy = bsy; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic probe(input string n, input logic [15:0] fu, input logic [15:0] mt,
                       input logic [15:0] mv, input logic won, input logic bsy);
    push(n, fu, mt, mv, won, bsy, -1);
    probe_tgl = ~probe_tgl;
  endtask

  task automatic press_xy(input int x, input int y, output int c);
    @(negedge clk);
    mx = 12'(x);
    my = 12'(y);
    ml = 1'b1;
    c  = cyc;
  endtask

  task automatic press_card(input int i, output int c);
    press_xy(192 + 200 * (i % 4), 144 + 160 * (i / 4), c);
  endtask

  task automatic rel_wait(input int n);
    @(negedge clk);
    ml = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic set_start(input logic v, output int c);
    @(negedge clk);
    start = v;
    c = cyc;
  endtask

  // Monitor: one expected entry per observed output change or probe.
  initial begin
    #12;
    forever begin
      @(snap or probe_tgl);
      #1;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_change: got fu=%h mt=%h mv=%0d won=%b busy=%b at cycle %0d, required no change",
                 face_up, matched, moves, game_won, busy, cyc);
      end else begin
        mon_e = q.pop_front();
        checks++;
        if ({face_up, matched, moves, game_won, busy} !==
            {mon_e.fu, mon_e.mt, mon_e.mv, mon_e.won, mon_e.bsy}) begin
          errors++;
          $display("FAIL %s: got fu=%h mt=%h mv=%0d won=%b busy=%b, required fu=%h mt=%h mv=%0d won=%b busy=%b",
                   mon_e.name, face_up, matched, moves, game_won, busy,
                   mon_e.fu, mon_e.mt, mon_e.mv, mon_e.won, mon_e.bsy);
        end
        if (mon_e.cyc >= 0) begin
          checks++;
          if (cyc != mon_e.cyc) begin
            errors++;
            $display("FAIL %s_cycle: got cycle %0d, required %0d", mon_e.name, cyc, mon_e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    int c;
    int lo;
    int hi;
    for (int i = 0; i < 16; i++) cv[i*4 +: 4] = 4'(i / 2);
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    probe("reset", 16'h0000, 16'h0000, 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    set_start(1'b1, c);
    repeat (2) @(negedge clk);

    // First game: first flip, gap/outside/repeat clicks ignored, then a match.
    press_card(0, c);
    push("t1_flip0", 16'h0001, 16'h0000, 16'd0, 1'b0, 1'b0, c + 2);
    rel_wait(3);
    press_xy(272, 144, c);
    rel_wait(2);
    press_xy(192, 700, c);
    rel_wait(2);
    press_card(0, c);
    rel_wait(3);
    probe("t4_no_change", 16'h0001, 16'h0000, 16'd0, 1'b0, 1'b0);
    press_card(1, c);
    push("t2_flip1", 16'h0003, 16'h0000, 16'd1, 1'b0, 1'b1, c + 2);
    push("t2_match", 16'h0003, 16'h0003, 16'd1, 1'b0, 1'b0, c + 3);
    rel_wait(3);

    set_start(1'b0, c);
    push("abort1", 16'h0000, 16'h0000, 16'd0, 1'b0, 1'b0, c + 1);
    repeat (2) @(negedge clk);
    set_start(1'b1, c);
    repeat (2) @(negedge clk);

    // Mismatch reveal; a click during SHOW is dropped.
    press_card(0, c);
    push("t3_flip0", 16'h0001, 16'h0000, 16'd0, 1'b0, 1'b0, c + 2);
    rel_wait(3);
    press_card(2, c);
    push("t3_flip2", 16'h0005, 16'h0000, 16'd1, 1'b0, 1'b1, c + 2);
    rel_wait(2);
    probe("t3_show_hold", 16'h0005, 16'h0000, 16'd1, 1'b0, 1'b1);
    push("t3_show_end", 16'h0000, 16'h0000, 16'd1, 1'b0, 1'b0, c + 3 + int'(SHOW));
    press_card(4, lo);
    rel_wait(12);

    set_start(1'b0, c);
    push("abort2", 16'h0000, 16'h0000, 16'd0, 1'b0, 1'b0, c + 1);
    repeat (2) @(negedge clk);
    set_start(1'b1, c);
    repeat (2) @(negedge clk);

    // Full game: pairs (2p, 2p+1); pair 0 clicked on card corner pixels.
    for (int p = 0; p < 8; p++) begin
      lo = (1 << (2 * p)) - 1;
      hi = (1 << (2 * p + 2)) - 1;
      if (p == 0) press_xy(112, 84, c);
      else        press_card(2 * p, c);
      push("t5_first", 16'((1 << (2 * p + 1)) - 1), 16'(lo), 16'(p), 1'b0, 1'b0, c + 2);
      rel_wait(3);
      if (p == 0) press_xy(471, 203, c);
      else        press_card(2 * p + 1, c);
      push("t5_second", 16'(hi), 16'(lo), 16'(p + 1), 1'b0, 1'b1, c + 2);
      push("t5_match", 16'(hi), 16'(hi), 16'(p + 1), (p == 7), 1'b0, c + 3);
      rel_wait(4);
    end
    probe("t5_won_hold", 16'hFFFF, 16'hFFFF, 16'd8, 1'b1, 1'b0);
    press_card(5, c);
    rel_wait(3);
    set_start(1'b0, c);
    push("t5_won_exit", 16'h0000, 16'h0000, 16'd0, 1'b0, 1'b0, c + 1);
    repeat (2) @(negedge clk);

    // Asynchronous reset while in SHOW.
    set_start(1'b1, c);
    repeat (2) @(negedge clk);
    press_card(0, c);
    push("t6_flip0", 16'h0001, 16'h0000, 16'd0, 1'b0, 1'b0, c + 2);
    rel_wait(3);
    press_card(2, c);
    push("t6_flip2", 16'h0005, 16'h0000, 16'd1, 1'b0, 1'b1, c + 2);
    rel_wait(3);
    push("t6_async_rst", 16'h0000, 16'h0000, 16'd0, 1'b0, 1'b0, cyc);
    rst = 1'b0;
    #2;
`ifdef CARD_GRID_HOVER_EN
    checks++;
    if (hover_valid !== 1'b0 || hover_idx !== 4'd0) begin
      errors++;
      $display("FAIL hover_reset: got idx=%0d valid=%b, required idx=0 valid=0", hover_idx, hover_valid);
    end
`endif
    @(negedge clk);
    rst = 1'b1;
    mx = 12'd192;
    my = 12'd144;
    repeat (3) @(negedge clk);
`ifdef CARD_GRID_HOVER_EN
    checks++;
    if (hover_valid !== 1'b1 || hover_idx !== 4'd0) begin
      errors++;
      $display("FAIL hover_card0: got idx=%0d valid=%b, required idx=0 valid=1", hover_idx, hover_valid);
    end
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expect: got %0d pending entries, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
